// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between the core data path and a word-organised RAM.
// Optional alignment trap: define LSU_MISALIGN_TRAP_EN.
module lsu_mem_ctrl #(
    parameter int unsigned XLen      = 32,
    parameter int unsigned MemPos    = 1024,
    localparam int unsigned AddrWidth = $clog2(MemPos)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [2:0]           funct3_i,
    input  logic [XLen-1:0]      addr_i,
    input  logic [XLen-1:0]      wdata_i,
    output logic [XLen-1:0]      rdata_o,
    output logic                 ready_o,
    output logic                 misaligned_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic                 mem_we_o,
    output logic [XLen-1:0]      mem_wd_o,
    input  logic [XLen-1:0]      mem_rd_i
);

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWr,
        StDone,
        StErr
    } state_e;

    state_e      state;
    logic        op_we;
    logic [2:0]  op_funct3;
    logic [1:0]  op_lane;
    logic [15:0] op_wdata;
    logic        mem_we_r;
    logic        req_err;

    // Address bits above the word index are ignored, so the index wraps.
    logic unused_addr;
    assign unused_addr = ^addr_i[XLen-1:AddrWidth+2];

    function automatic logic bad_funct3(input logic we, input logic [2:0] f3);
        if (we) begin
            return !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
        end
        return (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    endfunction

    function automatic logic [XLen-1:0] load_extract(input logic [XLen-1:0] word,
                                                     input logic [2:0]      f3,
                                                     input logic [1:0]      lane);
        logic [XLen-1:0] shifted;
        logic [15:0]     half;
        logic            sgn;
        sgn     = !f3[2];
        shifted = word >> {lane, 3'b000};
        half    = lane[1] ? word[31:16] : word[15:0];
        unique case (f3[1:0])
            2'b00:   return {{(XLen-8){sgn & shifted[7]}}, shifted[7:0]};
            2'b01:   return {{(XLen-16){sgn & half[15]}}, half};
            default: return word;
        endcase
    endfunction

    function automatic logic [XLen-1:0] store_merge(input logic [XLen-1:0] word,
                                                    input logic [2:0]      f3,
                                                    input logic [1:0]      lane,
                                                    input logic [15:0]     wd);
        logic [XLen-1:0] merged;
        merged = word;
        if (f3[1:0] == 2'b00) begin
            for (int i = 0; i < 4; i++) begin
                if (lane == 2'(i)) begin
                    merged[8*i +: 8] = wd[7:0];
                end
            end
        end else if (lane[1]) begin
            merged[31:16] = wd;
        end else begin
            merged[15:0] = wd;
        end
        return merged;
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    logic align_err;
    assign align_err = (funct3_i[1:0] == 2'b01 && addr_i[0]) ||
                       (funct3_i == 3'b010 && addr_i[1:0] != 2'b00);
    assign req_err   = bad_funct3(we_i, funct3_i) || align_err;
`else
    assign req_err      = bad_funct3(we_i, funct3_i);
    assign misaligned_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= StIdle;
            op_we        <= 1'b0;
            op_funct3    <= 3'b000;
            op_lane      <= 2'b00;
            op_wdata     <= '0;
            rdata_o      <= '0;
            ready_o      <= 1'b0;
            mem_addr_o   <= '0;
            mem_we_r     <= 1'b0;
            mem_wd_o     <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misaligned_o <= 1'b0;
`endif
        end else begin
            ready_o  <= 1'b0;
            mem_we_r <= 1'b0;
            mem_wd_o <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misaligned_o <= 1'b0;
`endif
            unique case (state)
                StIdle: begin
                    if (req_i) begin
                        op_we      <= we_i;
                        op_funct3  <= funct3_i;
                        op_lane    <= addr_i[1:0];
                        op_wdata   <= wdata_i[15:0];
                        mem_addr_o <= addr_i[AddrWidth+1:2];
                        if (req_err) begin
                            state   <= StErr;
                            ready_o <= 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
                            misaligned_o <= 1'b1;
`endif
                        end else if (we_i && funct3_i == 3'b010) begin
                            // Word stores skip the read: nothing to merge.
                            state    <= StWr;
                            mem_we_r <= 1'b1;
                            mem_wd_o <= wdata_i;
                        end else begin
                            state <= StRd;
                        end
                    end
                end
                StRd: begin
                    if (op_we) begin
                        state    <= StWr;
                        mem_we_r <= 1'b1;
                        mem_wd_o <= store_merge(mem_rd_i, op_funct3, op_lane, op_wdata);
                    end else begin
                        state   <= StDone;
                        ready_o <= 1'b1;
                        rdata_o <= load_extract(mem_rd_i, op_funct3, op_lane);
                    end
                end
                StWr: begin
                    state   <= StDone;
                    ready_o <= 1'b1;
                end
                StDone:  state <= StIdle;
                StErr:   state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    // Gated so a reset arriving during WR can never corrupt RAM.
    assign mem_we_o = mem_we_r & ~rst_i;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed table-driven bench for lsu_mem_ctrl with a behavioural RAM.
module tb_lsu_mem_ctrl;

    localparam int unsigned MemPos = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  f3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready;
    logic        misaligned;
    logic [9:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] ram [MemPos];

    int checks = 0;
    int errors = 0;

    lsu_mem_ctrl #(.XLen(32), .MemPos(MemPos)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .we_i         (we),
        .funct3_i     (f3),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .rdata_o      (rdata),
        .ready_o      (ready),
        .misaligned_o (misaligned),
        .mem_addr_o   (mem_addr),
        .mem_we_o     (mem_we),
        .mem_wd_o     (mem_wd),
        .mem_rd_i     (mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = ram[mem_addr];

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wd;
    end

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
        logic        exp_mis;
        int          exp_wec;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called in an IDLE cycle; returns one cycle after the ready pulse.
    task automatic do_op(input logic op_we, input logic [2:0] op_f3, input logic [31:0] op_a,
                         input logic [31:0] op_wd, output int lat, output int wec,
                         output logic mis, output logic [31:0] rd);
        req = 1'b1; we = op_we; f3 = op_f3; addr = op_a; wdata = op_wd;
        lat = 0; wec = 0; mis = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (mem_we) wec++;
            if (ready) begin
                lat = c;
                mis = misaligned;
                break;
            end
        end
        req = 1'b0;
        rd = rdata;
        @(posedge clk); #1;
    endtask

    initial begin
        int          lat;
        int          wec;
        logic        mis;
        logic [31:0] rd;
        logic        saw_ready;
        int          gap;

        for (int i = 0; i < int'(MemPos); i++) ram[i] = '0;
        ram[4] = 32'h8081_82F3;

`ifdef LSU_MISALIGN_TRAP_EN
        vecs[9]  = '{"lw_unaligned", 1'b0, 3'b010, 32'h22, 32'h0, 32'hDEAD_BEEF, 1, 1'b1, 0};
        vecs[17] = '{"lh_odd", 1'b0, 3'b001, 32'h11, 32'h0, 32'h7F81_AAF3, 1, 1'b1, 0};
`else
        vecs[9]  = '{"lw_unaligned", 1'b0, 3'b010, 32'h22, 32'h0, 32'h0BAD_F00D, 2, 1'b0, 0};
        vecs[17] = '{"lh_odd", 1'b0, 3'b001, 32'h11, 32'h0, 32'hFFFF_AAF3, 2, 1'b0, 0};
`endif
        vecs[0]  = '{"lb_lane2", 1'b0, 3'b000, 32'h12, 32'h0, 32'hFFFF_FF81, 2, 1'b0, 0};
        vecs[1]  = '{"lbu_lane2", 1'b0, 3'b100, 32'h12, 32'h0, 32'h0000_0081, 2, 1'b0, 0};
        vecs[2]  = '{"lh_lo", 1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFF_82F3, 2, 1'b0, 0};
        vecs[3]  = '{"lhu_hi", 1'b0, 3'b101, 32'h12, 32'h0, 32'h0000_8081, 2, 1'b0, 0};
        vecs[4]  = '{"sb_lane1", 1'b1, 3'b000, 32'h11, 32'h1234_56AA, 32'h0000_8081, 3, 1'b0, 1};
        vecs[5]  = '{"lw_after_sb", 1'b0, 3'b010, 32'h10, 32'h0, 32'h8081_AAF3, 2, 1'b0, 0};
        vecs[6]  = '{"sw_w8", 1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, 32'h8081_AAF3, 2, 1'b0, 1};
        vecs[7]  = '{"lw_w8", 1'b0, 3'b010, 32'h20, 32'h0, 32'hDEAD_BEEF, 2, 1'b0, 0};
        vecs[8]  = '{"sw_wrap", 1'b1, 3'b010, 32'h1020, 32'h0BAD_F00D, 32'hDEAD_BEEF, 2, 1'b0, 1};
        vecs[10] = '{"sh_hi_w5", 1'b1, 3'b001, 32'h16, 32'hFFFF_1234, vecs[9].exp_rdata, 3, 1'b0, 1};
        vecs[11] = '{"lhu_w5", 1'b0, 3'b101, 32'h16, 32'h0, 32'h0000_1234, 2, 1'b0, 0};
        vecs[12] = '{"bad_load_f3", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0000_1234, 1, 1'b0, 0};
        vecs[13] = '{"bad_store_f3", 1'b1, 3'b100, 32'h10, 32'hFFFF_FFFF, 32'h0000_1234, 1, 1'b0, 0};
        vecs[14] = '{"lb_lane3", 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFF_FF80, 2, 1'b0, 0};
        vecs[15] = '{"sb_lane3", 1'b1, 3'b000, 32'h13, 32'h0000_007F, 32'hFFFF_FF80, 3, 1'b0, 1};
        vecs[16] = '{"lw_after_sb3", 1'b0, 3'b010, 32'h10, 32'h0, 32'h7F81_AAF3, 2, 1'b0, 0};
`ifdef LSU_MISALIGN_TRAP_EN
        // The trap mode rejects the odd bad_store_f3 entry too; misaligned flags all ERR exits.
        vecs[12].exp_mis = 1'b1;
        vecs[13].exp_mis = 1'b1;
`endif

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_ready", {31'b0, ready}, 32'h0);
        chk("rst_mis", {31'b0, misaligned}, 32'h0);
        chk("rst_mem_addr", {22'b0, mem_addr}, 32'h0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
        chk("rst_mem_wd", mem_wd, 32'h0);

        for (int i = 0; i < 18; i++) begin
            do_op(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, lat, wec, mis, rd);
            chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
            chk({vecs[i].name, "_lat"}, lat, vecs[i].exp_lat);
            chk({vecs[i].name, "_mis"}, {31'b0, mis}, {31'b0, vecs[i].exp_mis});
            chk({vecs[i].name, "_wecnt"}, wec, vecs[i].exp_wec);
        end

        chk("ram_w4", ram[4], 32'h7F81_AAF3);
        chk("ram_w5", ram[5], 32'h1234_0000);
        chk("ram_w8", ram[8], 32'h0BAD_F00D);

        // Reset arriving in the WR cycle of an SH must suppress the write and the ready.
        req = 1'b1; we = 1'b1; f3 = 3'b001; addr = 32'h18; wdata = 32'h0000_5555;
        @(posedge clk); #1;
        chk("sh_rst_rd_no_we", {31'b0, mem_we}, 32'h0);
        @(posedge clk); #1;
        chk("sh_rst_wr_we", {31'b0, mem_we}, 32'h1);
        rst = 1'b1;
        #1;
        chk("sh_rst_we_gated", {31'b0, mem_we}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        req = 1'b0;
        chk("sh_rst_rdata", rdata, 32'h0);
        chk("sh_rst_ready", {31'b0, ready}, 32'h0);
        chk("sh_rst_mis", {31'b0, misaligned}, 32'h0);
        chk("sh_rst_mem_addr", {22'b0, mem_addr}, 32'h0);
        chk("sh_rst_mem_wd", mem_wd, 32'h0);
        chk("sh_rst_ram_w6", ram[6], 32'h0);
        saw_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (ready) saw_ready = 1'b1;
        end
        chk("sh_rst_no_ready", {31'b0, saw_ready}, 32'h0);

        // req held high through ready: the IDLE cycle after DONE accepts the next op.
        req = 1'b1; we = 1'b0; f3 = 3'b010; addr = 32'h10; wdata = '0;
        lat = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (ready) begin
                lat = c;
                break;
            end
        end
        chk("b2b_first_lat", lat, 2);
        chk("b2b_first_rdata", rdata, 32'h7F81_AAF3);
        f3 = 3'b100; addr = 32'h12;
        gap = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (ready) begin
                gap = c;
                break;
            end
        end
        req = 1'b0;
        chk("b2b_second_gap", gap, 3);
        chk("b2b_second_rdata", rdata, 32'h0000_0081);
        @(posedge clk); #1;
        chk("b2b_idle_ready", {31'b0, ready}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
